// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster timing generator
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] xcounter,
    output logic [9:0] ycounter,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic [9:0] max_x,
    output logic [9:0] max_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
    endgenerate

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

    phase_t     h_phase, v_phase, h_phase_nxt, v_phase_nxt;
    logic [9:0] x_nxt, y_nxt;
    logic       x_wrap, y_wrap;

    assign max_x = 10'(H_ACTIVE);
    assign max_y = 10'(V_ACTIVE);

    // Next-pixel values; only committed on pix_en edges so the
    // registered syncs line up with the counters they are decoded from.
    always_comb begin
        x_wrap      = (xcounter == H_LAST);
        y_wrap      = (ycounter == V_LAST);
        x_nxt       = x_wrap ? 10'd0 : xcounter + 10'd1;
        y_nxt       = ycounter;
        h_phase_nxt = h_phase;
        v_phase_nxt = v_phase;
        if (x_wrap) begin
            y_nxt = y_wrap ? 10'd0 : ycounter + 10'd1;
        end
        case (h_phase)
            PH_ACTIVE: if (x_nxt == H_FP_START)   h_phase_nxt = PH_FP;
            PH_FP:     if (x_nxt == H_SYNC_START) h_phase_nxt = PH_SYNC;
            PH_SYNC:   if (x_nxt == H_BP_START)   h_phase_nxt = PH_BP;
            PH_BP:     if (x_nxt == 10'd0)        h_phase_nxt = PH_ACTIVE;
        endcase
        if (x_wrap) begin
            case (v_phase)
                PH_ACTIVE: if (y_nxt == V_FP_START)   v_phase_nxt = PH_FP;
                PH_FP:     if (y_nxt == V_SYNC_START) v_phase_nxt = PH_SYNC;
                PH_SYNC:   if (y_nxt == V_BP_START)   v_phase_nxt = PH_BP;
                PH_BP:     if (y_nxt == 10'd0)        v_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xcounter    <= 10'd0;
            ycounter    <= 10'd0;
            h_phase     <= PH_ACTIVE;
            v_phase     <= PH_ACTIVE;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else if (pix_en) begin
            xcounter    <= x_nxt;
            ycounter    <= y_nxt;
            h_phase     <= h_phase_nxt;
            v_phase     <= v_phase_nxt;
            hsync       <= (h_phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            video_on    <= (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
            line_start  <= x_wrap;
            frame_start <= x_wrap && y_wrap;
            if (x_wrap && y_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] b_x, b_y, b_mx, b_my;
    logic       b_hs, b_vs, b_vo, b_ls, b_fs;
    logic [7:0] b_fc;

    logic [9:0] s_x, s_y, s_mx, s_my;
    logic       s_hs, s_vs, s_vo, s_ls, s_fs;
    logic [7:0] s_fc;

    logic [9:0] p_x, p_y, p_mx, p_my;
    logic       p_hs, p_vs, p_vo, p_ls, p_fs;
    logic [7:0] p_fc;

    vga_timing_gen u_big (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .xcounter(b_x), .ycounter(b_y), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_vo), .line_start(b_ls), .frame_start(b_fs),
        .frame_count(b_fc), .max_x(b_mx), .max_y(b_my)
    );

    // Small raster: 12 x 8, hsync on x 8..9, vsync on y 5..6, active 6 x 4
    vga_timing_gen #(
        .H_ACTIVE(6), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .xcounter(s_x), .ycounter(s_y), .hsync(s_hs), .vsync(s_vs),
        .video_on(s_vo), .line_start(s_ls), .frame_start(s_fs),
        .frame_count(s_fc), .max_x(s_mx), .max_y(s_my)
    );

    vga_timing_gen #(
        .H_ACTIVE(6), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_pol (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .xcounter(p_x), .ycounter(p_y), .hsync(p_hs), .vsync(p_vs),
        .video_on(p_vo), .line_start(p_ls), .frame_start(p_fs),
        .frame_count(p_fc), .max_x(p_mx), .max_y(p_my)
    );

    typedef struct {
        int x, y, hs, vs, vo, ls, fs, fc;
    } exp_t;

    typedef struct {
        logic rst, pe;
        int   x, y, ls, fs;
    } vec_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    int mx = 0, my = 0, mfc = 0, mls = 0, mfs = 0;
    int bx, by;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference raster for the small instances, advanced once per driven edge.
    task automatic drive_cycle(input logic r, input logic pe);
        exp_t e;
        reset  = r;
        pix_en = pe;
        if (r) begin
            mx = 0; my = 0; mfc = 0; mls = 0; mfs = 0;
        end else if (pe) begin
            mls = (mx == 11) ? 1 : 0;
            mfs = (mls == 1 && my == 7) ? 1 : 0;
            if (mls == 1) begin
                mx = 0;
                my = (my == 7) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            if (mfs == 1) mfc = (mfc + 1) % 256;
        end else begin
            mls = 0; mfs = 0;
        end
        e.x  = mx;
        e.y  = my;
        e.hs = (mx >= 8 && mx <= 9) ? 0 : 1;
        e.vs = (my >= 5 && my <= 6) ? 0 : 1;
        e.vo = (mx < 6 && my < 4) ? 1 : 0;
        e.ls = mls;
        e.fs = mfs;
        e.fc = mfc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("s_x", int'(s_x), e.x);
        check("s_y", int'(s_y), e.y);
        check("s_hsync", int'(s_hs), e.hs);
        check("s_vsync", int'(s_vs), e.vs);
        check("s_video_on", int'(s_vo), e.vo);
        check("s_line_start", int'(s_ls), e.ls);
        check("s_frame_start", int'(s_fs), e.fs);
        check("s_frame_count", int'(s_fc), e.fc);
        check("p_hsync", int'(p_hs), 1 - e.hs);
        check("p_vsync", int'(p_vs), 1 - e.vs);
        check("p_x", int'(p_x), e.x);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 2, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 3, 0, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 4, 0, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 5, 0, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 6, 0, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 7, 0, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 8, 0, 0, 0};
        vecs[10] = '{1'b0, 1'b1, 9, 0, 0, 0};
        vecs[11] = '{1'b0, 1'b1, 10, 0, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 11, 0, 0, 0};
        vecs[13] = '{1'b0, 1'b1, 0, 1, 1, 0};
        vecs[14] = '{1'b0, 1'b0, 0, 1, 0, 0};
        vecs[15] = '{1'b0, 1'b1, 1, 1, 0, 0};

        // Full-size raster, line 0 and the first line wrap
        drive_cycle(1'b1, 1'b0);
        check("big_reset_x", int'(b_x), 0);
        check("big_reset_hsync", int'(b_hs), 1);
        check("big_reset_vsync", int'(b_vs), 1);
        check("big_reset_video_on", int'(b_vo), 1);
        check("big_max_x", int'(b_mx), 640);
        check("big_max_y", int'(b_my), 480);
        check("small_max_x", int'(s_mx), 6);
        bx = 0; by = 0;
        for (int i = 1; i <= 801; i++) begin
            drive_cycle(1'b0, 1'b1);
            bx++;
            if (bx == 800) begin
                bx = 0;
                by++;
            end
            check("big_x", int'(b_x), bx);
            check("big_y", int'(b_y), by);
            check("big_hsync", int'(b_hs), (bx >= 656 && bx < 752) ? 0 : 1);
            check("big_vsync", int'(b_vs), 1);
            check("big_video_on", int'(b_vo), (bx < 640) ? 1 : 0);
            check("big_line_start", int'(b_ls), (bx == 0) ? 1 : 0);
            check("big_frame_start", int'(b_fs), 0);
        end

        // Table vectors against the small raster
        for (int i = 0; i < 16; i++) begin
            drive_cycle(vecs[i].rst, vecs[i].pe);
            check($sformatf("vec%0d_x", i), int'(s_x), vecs[i].x);
            check($sformatf("vec%0d_y", i), int'(s_y), vecs[i].y);
            check($sformatf("vec%0d_ls", i), int'(s_ls), vecs[i].ls);
            check($sformatf("vec%0d_fs", i), int'(s_fs), vecs[i].fs);
        end

        // Sparse pix_en over two frames; pulses stay one clk wide
        for (int i = 0; i < 420; i++) begin
            drive_cycle(1'b0, (i % 2) == 0);
        end

        // Mid-frame reset at x=3, y=2
        for (int i = 0; i < 200 && !(mx == 3 && my == 2); i++) begin
            drive_cycle(1'b0, 1'b1);
        end
        check("pre_reset_x", int'(s_x), 3);
        check("pre_reset_y", int'(s_y), 2);
        drive_cycle(1'b1, 1'b1);
        check("mid_reset_x", int'(s_x), 0);
        check("mid_reset_y", int'(s_y), 0);
        check("mid_reset_video_on", int'(s_vo), 1);
        check("mid_reset_hsync", int'(s_hs), 1);
        check("mid_reset_vsync", int'(s_vs), 1);
        check("mid_reset_frame_count", int'(s_fc), 0);
        check("mid_reset_pol_hsync", int'(p_hs), 0);

        // 256 frames: frame_count reaches 255 then wraps on the frame_start edge
        for (int i = 1; i <= 256 * 96; i++) begin
            drive_cycle(1'b0, 1'b1);
            if (i == 96) begin
                check("first_frame_fs", int'(s_fs), 1);
                check("first_frame_fc", int'(s_fc), 1);
            end
            if (i == 256 * 96 - 1) begin
                check("fc_255", int'(s_fc), 255);
                check("fc_255_fs", int'(s_fs), 0);
            end
            if (i == 256 * 96) begin
                check("fc_wrap", int'(s_fc), 0);
                check("fc_wrap_fs", int'(s_fs), 1);
                check("fc_wrap_ls", int'(s_ls), 1);
                check("fc_wrap_x", int'(s_x), 0);
                check("fc_wrap_y", int'(s_y), 0);
            end
        end
        drive_cycle(1'b0, 1'b1);
        check("post_wrap_fs", int'(s_fs), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
